// File: rtl/segway_math_pkg.sv
// Shared constants and helpers for the Segway torque math pipeline.
package segway_math_pkg;

  // Default shaping and overspeed constants
  localparam int DEF_MIN_DUTY        = 'h3C0;
  localparam int DEF_LOW_TORQUE_BAND = 'h3C;
  localparam int DEF_GAIN_MULT       = 16;
  localparam int DEF_TOO_FAST_THRESH = 1792;
  localparam int DEF_TOO_FAST_CNT    = 4;
  localparam int DEF_SLEW_STEP       = 'h040;

  // Steering pot clamp window and electrical centre
  localparam logic [11:0] STEER_MIN = 12'h200;
  localparam logic [11:0] STEER_MAX = 12'hE00;
  localparam logic [11:0] STEER_CTR = 12'h7FF;

  // Clamp v into the signed range of a w-bit two's complement value
  function automatic int sat_signed(input int v, input int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/segway_math_pipe_shaper.sv
// Deadzone shaping plus saturation of one wheel torque.
module segway_shaper
  import segway_math_pkg::*;
#(
  parameter int DW              = 12,
  parameter int MIN_DUTY        = DEF_MIN_DUTY,
  parameter int LOW_TORQUE_BAND = DEF_LOW_TORQUE_BAND,
  parameter int GAIN_MULT       = DEF_GAIN_MULT
) (
  input  logic signed [DW:0]   torque,
  output logic signed [DW-1:0] shaped
);

  int t;
  int mag;
  int v;

  // Large torques get a fixed offset past the motor deadzone, small ones a gain boost
  always_comb begin
    t   = int'(torque);
    mag = (t < 0) ? -t : t;
    if (mag > LOW_TORQUE_BAND) begin
      v = (t < 0) ? (t - MIN_DUTY) : (t + MIN_DUTY);
    end else begin
      v = t * GAIN_MULT;
    end
    shaped = DW'(sat_signed(v, DW));
  end

endmodule

// File: rtl/segway_math_pipe.sv
// Three-stage pipelined torque math: soft-start, steering mix, shaping, slew limit
// and debounced overspeed detection.
module segway_math_pipe
  import segway_math_pkg::*;
#(
  parameter int DW              = 12,
  parameter int SS_W            = 8,
  parameter int MIN_DUTY        = DEF_MIN_DUTY,
  parameter int LOW_TORQUE_BAND = DEF_LOW_TORQUE_BAND,
  parameter int GAIN_MULT       = DEF_GAIN_MULT,
  parameter int TOO_FAST_THRESH = DEF_TOO_FAST_THRESH,
  parameter int TOO_FAST_CNT    = DEF_TOO_FAST_CNT,
  parameter int SLEW_STEP       = DEF_SLEW_STEP
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vld_in,
  input  logic signed [DW-1:0] PID_cntrl,
  input  logic [11:0]          steer_pot,
  input  logic                 en_steer,
  input  logic                 pwr_up,
  output logic signed [DW-1:0] lft_spd,
  output logic signed [DW-1:0] rght_spd,
  output logic                 vld_out,
  output logic                 too_fast
);

  localparam int                 CntW   = $clog2(TOO_FAST_CNT + 1);
  localparam logic [CntW-1:0]    CntMax = CntW'(TOO_FAST_CNT);
  localparam logic [SS_W-1:0]    SsMax  = '1;

  logic [SS_W-1:0]          ss_tmr_q;

  // Stage 1 signals
  logic signed [DW+SS_W:0]  pid_ext;
  logic signed [DW+SS_W:0]  ss_ext;
  logic signed [DW+SS_W:0]  prod;
  logic signed [DW-1:0]     pid_ss_d;
  logic [11:0]              steer_sat;
  logic signed [11:0]       steer_ofs;
  logic signed [DW:0]       steer_term_d;
  logic                     v1_q;
  logic signed [DW-1:0]     pid_ss_q;
  logic signed [DW:0]       steer_q;
  logic                     en_q;

  // Stage 2 signals
  logic signed [DW:0]       steer_eff;
  logic signed [DW:0]       lft_torque;
  logic signed [DW:0]       rght_torque;
  logic signed [DW-1:0]     lft_shaped;
  logic signed [DW-1:0]     rght_shaped;
  logic                     v2_q;
  logic signed [DW-1:0]     lft_tgt_q;
  logic signed [DW-1:0]     rght_tgt_q;

  // Stage 3 signals
  logic signed [DW-1:0]     lft_d;
  logic signed [DW-1:0]     rght_d;
  logic                     over;
  logic [CntW-1:0]          cnt_q;
  logic [CntW-1:0]          cnt_d;

  // Move cur toward tgt by at most SLEW_STEP
  function automatic logic signed [DW-1:0] slew(input logic signed [DW-1:0] cur,
                                                input logic signed [DW-1:0] tgt);
    int delta;
    int r;
    delta = int'(tgt) - int'(cur);
    if (delta > SLEW_STEP) begin
      r = int'(cur) + SLEW_STEP;
    end else if (delta < -SLEW_STEP) begin
      r = int'(cur) - SLEW_STEP;
    end else begin
      r = int'(tgt);
    end
    return DW'(r);
  endfunction

  // Soft-start ramp: counts samples while powered, saturates, clears on power loss
  always_ff @(posedge clk) begin
    if (rst || !pwr_up) begin
      ss_tmr_q <= '0;
    end else if (vld_in && (ss_tmr_q != SsMax)) begin
      ss_tmr_q <= ss_tmr_q + 1'b1;
    end
  end

  // Stage 1 datapath: soft-start scaling and 3/16 steering term
  always_comb begin
    pid_ext  = (DW+SS_W+1)'(PID_cntrl);
    ss_ext   = {{(DW+1){1'b0}}, ss_tmr_q};
    prod     = pid_ext * ss_ext;
    pid_ss_d = DW'(prod >>> SS_W);
    if (steer_pot < STEER_MIN) begin
      steer_sat = STEER_MIN;
    end else if (steer_pot > STEER_MAX) begin
      steer_sat = STEER_MAX;
    end else begin
      steer_sat = steer_pot;
    end
    steer_ofs    = steer_sat - STEER_CTR;
    steer_term_d = (DW+1)'(steer_ofs >>> 4) + (DW+1)'(steer_ofs >>> 3);
  end

  // Stage 1 registers; power loss zeroes the data so in-flight samples come out as 0
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      pid_ss_q <= '0;
      steer_q  <= '0;
      en_q     <= 1'b0;
    end else begin
      v1_q <= vld_in;
      if (!pwr_up) begin
        pid_ss_q <= '0;
        steer_q  <= '0;
      end else if (vld_in) begin
        pid_ss_q <= pid_ss_d;
        steer_q  <= steer_term_d;
        en_q     <= en_steer;
      end
    end
  end

  // Stage 2 datapath: differential steering mix
  always_comb begin
    steer_eff   = en_q ? steer_q : '0;
    lft_torque  = (DW+1)'(pid_ss_q) + steer_eff;
    rght_torque = (DW+1)'(pid_ss_q) - steer_eff;
  end

  segway_shaper #(
    .DW              (DW),
    .MIN_DUTY        (MIN_DUTY),
    .LOW_TORQUE_BAND (LOW_TORQUE_BAND),
    .GAIN_MULT       (GAIN_MULT)
  ) u_shaper_lft (
    .torque (lft_torque),
    .shaped (lft_shaped)
  );

  segway_shaper #(
    .DW              (DW),
    .MIN_DUTY        (MIN_DUTY),
    .LOW_TORQUE_BAND (LOW_TORQUE_BAND),
    .GAIN_MULT       (GAIN_MULT)
  ) u_shaper_rght (
    .torque (rght_torque),
    .shaped (rght_shaped)
  );

  // Stage 2 registers: shaped, saturated targets
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q       <= 1'b0;
      lft_tgt_q  <= '0;
      rght_tgt_q <= '0;
    end else begin
      v2_q <= v1_q;
      if (!pwr_up) begin
        lft_tgt_q  <= '0;
        rght_tgt_q <= '0;
      end else if (v1_q) begin
        lft_tgt_q  <= lft_shaped;
        rght_tgt_q <= rght_shaped;
      end
    end
  end

  // Stage 3 next state: slew limit, power-loss override and overspeed debounce
  always_comb begin
    lft_d  = lft_spd;
    rght_d = rght_spd;
    cnt_d  = cnt_q;
    if (!pwr_up) begin
      lft_d  = '0;
      rght_d = '0;
    end else if (v2_q) begin
      lft_d  = slew(lft_spd, lft_tgt_q);
      rght_d = slew(rght_spd, rght_tgt_q);
    end
    over = (int'(lft_d) > TOO_FAST_THRESH) || (int'(rght_d) > TOO_FAST_THRESH);
    if (!pwr_up) begin
      cnt_d = '0;
    end else if (v2_q) begin
      if (over) begin
        cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
      end else begin
        cnt_d = '0;
      end
    end
  end

  // Stage 3 output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      lft_spd  <= '0;
      rght_spd <= '0;
      vld_out  <= 1'b0;
      cnt_q    <= '0;
      too_fast <= 1'b0;
    end else begin
      lft_spd  <= lft_d;
      rght_spd <= rght_d;
      vld_out  <= v2_q;
      cnt_q    <= cnt_d;
      too_fast <= (cnt_d == CntMax);
    end
  end

endmodule

// File: tb/tb_segway_math_pipe.sv
// Self-checking bench: two DUTs (default slew and wide slew) on shared stimulus,
// scoreboard of expected outputs popped on vld_out.
module tb_segway_math_pipe;

  logic               clk = 1'b0;
  logic               rst;
  logic               vld_in;
  logic signed [11:0] pid;
  logic [11:0]        steer_pot;
  logic               en_steer;
  logic               pwr_up;
  logic signed [11:0] lft_a, rght_a, lft_b, rght_b;
  logic               vld_a, vld_b, tf_a, tf_b;

  typedef struct {
    logic signed [11:0] la;
    logic signed [11:0] ra;
    logic signed [11:0] lb;
    logic signed [11:0] rb;
    int                 cyc;
  } exp_t;

  typedef struct {
    logic [11:0] pid;
    logic [11:0] steer;
    logic        en;
    logic [11:0] tl;
    logic [11:0] tr;
  } vec_t;

  exp_t               sbq[$];
  vec_t               tbl[14];
  int                 checks = 0;
  int                 fails  = 0;
  int                 cyc    = 0;
  logic signed [11:0] cur_la, cur_ra, cur_lb, cur_rb;
  int                 cnt_a, cnt_b;

  segway_math_pipe dut_a (
    .clk       (clk),
    .rst       (rst),
    .vld_in    (vld_in),
    .PID_cntrl (pid),
    .steer_pot (steer_pot),
    .en_steer  (en_steer),
    .pwr_up    (pwr_up),
    .lft_spd   (lft_a),
    .rght_spd  (rght_a),
    .vld_out   (vld_a),
    .too_fast  (tf_a)
  );

  segway_math_pipe #(
    .SLEW_STEP ('h7FF)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .vld_in    (vld_in),
    .PID_cntrl (pid),
    .steer_pot (steer_pot),
    .en_steer  (en_steer),
    .pwr_up    (pwr_up),
    .lft_spd   (lft_b),
    .rght_spd  (rght_b),
    .vld_out   (vld_b),
    .too_fast  (tf_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [11:0] lim(input logic signed [11:0] cur,
                                             input logic signed [11:0] tgt, input int step);
    int d;
    d = int'(tgt) - int'(cur);
    if (d > step) return 12'(int'(cur) + step);
    if (d < -step) return 12'(int'(cur) - step);
    return tgt;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    vld_in = 1'b0;
    repeat (n) step();
  endtask

  // Drive one sample whose shaped targets are tl/tr; expected outputs follow the slew model
  task automatic send(input logic [11:0] p, input logic [11:0] s, input logic en,
                      input logic [11:0] tl, input logic [11:0] tr);
    exp_t e;
    pid       = p;
    steer_pot = s;
    en_steer  = en;
    vld_in    = 1'b1;
    cur_la = lim(cur_la, tl, 'h40);
    cur_ra = lim(cur_ra, tr, 'h40);
    cur_lb = lim(cur_lb, tl, 'h7FF);
    cur_rb = lim(cur_rb, tr, 'h7FF);
    e.la  = cur_la;
    e.ra  = cur_ra;
    e.lb  = cur_lb;
    e.rb  = cur_rb;
    e.cyc = cyc;
    sbq.push_back(e);
    step();
  endtask

  // One cycle of pwr_up low; in-flight samples are expected to emerge as zero
  task automatic pwr_drop();
    exp_t e;
    vld_in = 1'b0;
    pwr_up = 1'b0;
    for (int i = 0; i < sbq.size(); i++) begin
      e    = sbq[i];
      e.la = '0;
      e.ra = '0;
      e.lb = '0;
      e.rb = '0;
      sbq[i] = e;
    end
    cur_la = '0; cur_ra = '0; cur_lb = '0; cur_rb = '0;
    cnt_a = 0; cnt_b = 0;
    step();
    pwr_up = 1'b1;
    check("pwr_lft_a", 32'(lft_a), 32'h0);
    check("pwr_rght_a", 32'(rght_a), 32'h0);
    check("pwr_lft_b", 32'(lft_b), 32'h0);
    check("pwr_rght_b", 32'(rght_b), 32'h0);
    check("pwr_tf_b", 32'(tf_b), 32'h0);
  endtask

  // Scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    exp_t e;
    logic ov;
    if (vld_a || vld_b) begin
      if (sbq.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_vld: got vld_a=%0b vld_b=%0b expected none (t=%0t)",
                 vld_a, vld_b, $time);
      end else begin
        e = sbq.pop_front();
        check("vld_a", 32'(vld_a), 32'h1);
        check("vld_b", 32'(vld_b), 32'h1);
        check("latency", 32'(cyc), 32'(e.cyc + 3));
        check("lft_a", 32'(lft_a), 32'(e.la));
        check("rght_a", 32'(rght_a), 32'(e.ra));
        check("lft_b", 32'(lft_b), 32'(e.lb));
        check("rght_b", 32'(rght_b), 32'(e.rb));
        ov    = (int'(e.la) > 1792) || (int'(e.ra) > 1792);
        cnt_a = ov ? ((cnt_a < 4) ? cnt_a + 1 : 4) : 0;
        ov    = (int'(e.lb) > 1792) || (int'(e.rb) > 1792);
        cnt_b = ov ? ((cnt_b < 4) ? cnt_b + 1 : 4) : 0;
        check("too_fast_a", 32'(tf_a), 32'(cnt_a == 4));
        check("too_fast_b", 32'(tf_b), 32'(cnt_b == 4));
      end
    end else if (sbq.size() > 0 && cyc >= sbq[0].cyc + 3) begin
      e = sbq.pop_front();
      checks++;
      fails++;
      $display("FAIL missing_vld: got no vld_out expected one at cycle %0d", e.cyc + 3);
    end
  end

  initial begin
    tbl[0]  = '{12'h000, 12'h7FF, 1'b1, 12'h000, 12'h000};
    tbl[1]  = '{12'h000, 12'hFFF, 1'b1, 12'h4E0, 12'hB20};
    tbl[2]  = '{12'h000, 12'h000, 1'b1, 12'hB20, 12'h4E0};
    tbl[3]  = '{12'h000, 12'h100, 1'b1, 12'hB20, 12'h4E0};
    tbl[4]  = '{12'h000, 12'h800, 1'b1, 12'h000, 12'h000};
    tbl[5]  = '{12'h000, 12'h900, 1'b1, 12'h300, 12'hD00};
    tbl[6]  = '{12'h000, 12'h900, 1'b0, 12'h000, 12'h000};
    tbl[7]  = '{12'hF00, 12'h7FF, 1'b0, 12'hB41, 12'hB41};
    tbl[8]  = '{12'h040, 12'h7FF, 1'b0, 12'h3FF, 12'h3FF};
    tbl[9]  = '{12'h03D, 12'h7FF, 1'b0, 12'h3C0, 12'h3C0};
    tbl[10] = '{12'hFC3, 12'h7FF, 1'b0, 12'hC03, 12'hC03};
    tbl[11] = '{12'hFFE, 12'h7FF, 1'b0, 12'hFE0, 12'hFE0};
    tbl[12] = '{12'h7FF, 12'h7FF, 1'b0, 12'h7FF, 12'h7FF};
    tbl[13] = '{12'h800, 12'h7FF, 1'b0, 12'h800, 12'h800};

    rst = 1'b1; vld_in = 1'b0; pid = '0; steer_pot = 12'h7FF; en_steer = 1'b0; pwr_up = 1'b1;
    cur_la = '0; cur_ra = '0; cur_lb = '0; cur_rb = '0; cnt_a = 0; cnt_b = 0;
    repeat (3) step();
    check("rst_lft_a", 32'(lft_a), 32'h0);
    check("rst_rght_a", 32'(rght_a), 32'h0);
    check("rst_vld_a", 32'(vld_a), 32'h0);
    check("rst_tf_a", 32'(tf_a), 32'h0);
    check("rst_lft_b", 32'(lft_b), 32'h0);
    check("rst_vld_b", 32'(vld_b), 32'h0);
    rst = 1'b0;

    // Soft-start saturation: 256 samples must leave ss_tmr at 0xFF, not wrapped
    for (int i = 0; i < 256; i++) send(12'h000, 12'h7FF, 1'b0, 12'h000, 12'h000);
    send(12'h002, 12'h7FF, 1'b0, 12'h010, 12'h010);
    idle(4);
    for (int i = 0; i < 19; i++) begin
      send(12'h100, 12'h7FF, 1'b0, 12'h4BF, 12'h4BF);
      idle(1);
    end
    idle(4);
    check("climb_a_final", 32'(lft_a), 32'h4BF);

    // Table of shaping/steering vectors
    for (int i = 0; i < 14; i++) begin
      send(tbl[i].pid, tbl[i].steer, tbl[i].en, tbl[i].tl, tbl[i].tr);
      idle(1);
    end
    idle(4);

    // Overspeed debounce, back-to-back samples
    send(12'h000, 12'h7FF, 1'b0, 12'h000, 12'h000);
    send(12'h000, 12'h7FF, 1'b0, 12'h000, 12'h000);
    repeat (4) send(12'h7FF, 12'h7FF, 1'b0, 12'h7FF, 12'h7FF);
    send(12'h000, 12'h7FF, 1'b0, 12'h000, 12'h000);
    idle(5);
    repeat (4) send(12'h7FF, 12'h7FF, 1'b0, 12'h7FF, 12'h7FF);
    idle(5);
    check("tf_b_high", 32'(tf_b), 32'h1);
    pwr_drop();
    idle(3);

    // Re-saturate soft-start, climb, then drop power with samples in flight
    for (int i = 0; i < 260; i++) send(12'h000, 12'h7FF, 1'b0, 12'h000, 12'h000);
    for (int i = 0; i < 24; i++) begin
      send(12'h100, 12'h7FF, 1'b0, 12'h4BF, 12'h4BF);
      idle(1);
    end
    idle(4);
    check("climb_a_again", 32'(lft_a), 32'h4BF);
    send(12'h100, 12'h7FF, 1'b0, 12'h4BF, 12'h4BF);
    send(12'h100, 12'h7FF, 1'b0, 12'h4BF, 12'h4BF);
    pwr_drop();
    idle(4);
    // ss_tmr restarts at 0, then 1
    send(12'h100, 12'h7FF, 1'b0, 12'h000, 12'h000);
    idle(1);
    send(12'h100, 12'h7FF, 1'b0, 12'h010, 12'h010);
    idle(5);

    // Reset mid-stream discards in-flight samples
    send(12'h000, 12'hFFF, 1'b1, 12'h4E0, 12'hB20);
    send(12'h000, 12'hFFF, 1'b1, 12'h4E0, 12'hB20);
    send(12'h000, 12'hFFF, 1'b1, 12'h4E0, 12'hB20);
    vld_in = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    sbq.delete();
    cur_la = '0; cur_ra = '0; cur_lb = '0; cur_rb = '0; cnt_a = 0; cnt_b = 0;
    @(posedge clk);
    #1;
    check("mrst_vld_a", 32'(vld_a), 32'h0);
    check("mrst_lft_a", 32'(lft_a), 32'h0);
    check("mrst_rght_b", 32'(rght_b), 32'h0);
    check("mrst_tf_a", 32'(tf_a), 32'h0);
    rst = 1'b0;
    idle(6);
    send(12'h100, 12'h7FF, 1'b0, 12'h000, 12'h000);
    idle(6);
    check("queue_drained", 32'(sbq.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/segway_math_pipe.md
Name: segway_math_pipe

Overview:
Pipelined, parametrised successor to the combinational Segway torque math block. It takes the balance-PID output and the steering pot, and generates its own soft-start scaling internally instead of taking an external timer. It then applies deadzone shaping, saturation, per-sample slew-rate limiting and debounced overspeed detection. It sits between the balance controller and the PWM/motor-drive block and is qualified by a per-sample valid strobe.

Parameters:
DW, 12, signed width of PID_cntrl, lft_spd and rght_spd.
SS_W, 8, soft-start counter width; the scaled PID is PID_cntrl*ss_tmr >> SS_W.
MIN_DUTY, 13'h3C0, deadzone offset added to the magnitude of large torques.
LOW_TORQUE_BAND, 8'h3C, |torque| at or below this value uses the GAIN_MULT path.
GAIN_MULT, 16, small-torque gain.
TOO_FAST_THRESH, 1792, a signed speed strictly greater than this counts as too fast.
TOO_FAST_CNT, 4, number of consecutive too-fast output samples before too_fast asserts.
SLEW_STEP, 12'h040, maximum change of each speed output per valid output sample.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
vld_in  in  1  new PID sample strobe, one cycle per sample.
PID_cntrl  in  DW  signed PID output.
steer_pot  in  12  unsigned A2D steering reading.
en_steer  in  1  enables the steering term.
pwr_up  in  1  rider present and power enabled.
lft_spd  out  DW  signed left motor speed, registered.
rght_spd  out  DW  signed right motor speed, registered.
vld_out  out  1  lft_spd/rght_spd updated this cycle.
too_fast  out  1  debounced overspeed flag, registered.

Behaviour:
- Reset (rst=1 at a clk edge): ss_tmr=0, all pipeline valids=0, lft_spd=rght_spd=0, vld_out=0, too_fast=0, overspeed counter=0. Reset mid-pipeline discards in-flight samples.
- Soft-start counter: on vld_in with pwr_up=1, ss_tmr increments and saturates at all-ones (no wrap). pwr_up=0 clears it on the next edge regardless of vld_in.
- Pipeline: 3 stages, so vld_out follows vld_in by exactly 3 cycles. A stage's data register loads only when its incoming valid is 1 and holds otherwise. Back-to-back vld_in every cycle is supported.
- S1 (registered):
  - PID_ss = (PID_cntrl * {0,ss_tmr}) >>> SS_W, truncated to DW bits, signed.
  - steer_sat = steer_pot clamped to [0x200, 0xE00].
  - s = steer_sat - 0x7FF, 12-bit signed.
  - steer_term = (s>>>4)+(s>>>3), i.e. 3/16 scaling, sign-extended to DW+1.
- S2 (registered):
  - With en_steer=1: lft_torque = PID_ss + steer_term and rght_torque = PID_ss - steer_term, both DW+1 bits.
  - With en_steer=0: both torques = PID_ss.
  - Shaping: if |t| > LOW_TORQUE_BAND then t ± MIN_DUTY (sign of t), else t*GAIN_MULT.
  - The shaped value is saturated to DW signed, range [-2^(DW-1), 2^(DW-1)-1].
- S3 (output registers):
  - On a valid sample, delta = target - current (DW+1 bits).
  - If delta > SLEW_STEP, output = current + SLEW_STEP. If delta < -SLEW_STEP, output = current - SLEW_STEP. Otherwise output = target.
  - Any cycle with pwr_up=0 forces lft_spd=rght_spd=0 immediately, bypassing the slew limit. In-flight samples still raise vld_out but with value 0.
- too_fast:
  - On each vld_out, if lft_spd > TOO_FAST_THRESH or rght_spd > TOO_FAST_THRESH (signed compare on the newly loaded values), the counter increments, saturating at TOO_FAST_CNT. Otherwise the counter clears.
  - too_fast is registered and equals (counter == TOO_FAST_CNT). It asserts on the same edge as the TOO_FAST_CNT-th consecutive over-threshold vld_out and clears on the same edge as the first under-threshold vld_out.
  - pwr_up=0 clears the counter and too_fast.
- Simultaneous events: rst dominates pwr_up=0, which dominates vld_in.

Decomposition:
- Package segway_math_pkg holds the default constants (MIN_DUTY, LOW_TORQUE_BAND, GAIN_MULT, TOO_FAST_THRESH, steer clamp limits 0x200/0xE00, steer centre 0x7FF) and a sat_signed function.
- One sub-module, segway_shaper: combinational deadzone shaping plus saturation, instantiated once per wheel. Slew limiting and the counters stay in the top level.

Test Plan:
- Reset then 255 vld_in with PID_cntrl=0, pwr_up=1 -> ss_tmr=0xFF, no wrap on the 256th sample; lft_spd=rght_spd=0 throughout; vld_out exactly 3 cycles after each vld_in.
- ss_tmr=0xFF, PID_cntrl=0x002, en_steer=0 -> PID_ss=1, inside band, shaped=0x010; lft_spd=rght_spd=0x010 3 cycles later. Then PID_cntrl=0x100 -> target 0x4BF; outputs climb by 0x040 per sample and reach 0x4BF on the 19th sample.
- SLEW_STEP=0x7FF, ss_tmr=0xFF, PID_cntrl=0, en_steer=1, steer_pot=0xFFF -> steer_term=0x120; lft_spd=0x4E0, rght_spd=0xB20. Same with steer_pot=0x000 -> lft_spd=0xB20, rght_spd=0x4E0.
- SLEW_STEP=0x7FF, PID_cntrl=0x7FF, ss_tmr=0xFF -> shaped value saturates to lft_spd=0x7FF. too_fast rises with the 4th consecutive vld_out, not the 3rd. One sample with PID_cntrl=0 -> too_fast clears with that vld_out.
- Outputs at 0x4BF, pwr_up dropped for 1 cycle -> lft_spd=rght_spd=0 the next edge, ss_tmr=0, too_fast=0. In-flight samples emerge with value 0.
- Back-to-back vld_in, then rst high for 1 cycle mid-stream -> all outputs 0 and vld_out low on the next edge. No vld_out appears for the samples that were in flight at reset.
